// File: rtl/slc3_mem_bridge.sv
// slc3_mem_bridge: turns the SLC-3 MAR/MDR memory path into a valid/ready
// request channel with a one-cycle response pulse. SRAM reads insert RD_LAT
// wait states, and one address (IO_ADDR) is decoded as a memory-mapped I/O
// word: writes load the hex display, reads return the synchronised switches.
module slc3_mem_bridge #(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       ADDR_W  = 16,
    parameter int unsigned       RD_LAT  = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy_o,
    output logic              mem_ena,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] sw_i,
    output logic [DATA_W-1:0] hex_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MEM_RD = 2'd1;
    localparam logic [1:0] S_MEM_WR = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Counter wraps modulo 16; RD_LAT outside 1..15 is not guarded.
    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] hex_q,   hex_d;
    logic [DATA_W-1:0] sw_s1_q, sw_s2_q;

    // Two-flop synchroniser for the switch inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_i;
            sw_s2_q <= sw_s1_q;
        end
    end

    // Next-state logic: accept decode, wait-state countdown, response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_addr == IO_ADDR) begin
                        state_d = S_RESP;
                        if (req_we) begin
                            hex_d   = req_wdata;
                            rdata_d = '0;
                        end else begin
                            rdata_d = sw_s2_q;
                        end
                    end else if (req_we) begin
                        state_d = S_MEM_WR;
                        rdata_d = '0;
                    end else begin
                        state_d = S_MEM_RD;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_MEM_RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_MEM_WR: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

    // Output decode straight from state so reset clears strobes at once.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy_o    = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
        mem_ena   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        mem_we    = (state_q == S_MEM_WR);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign hex_o     = hex_q;

endmodule

// File: doc/slc3_mem_bridge.md
# slc3_mem_bridge

Parametrised memory/I-O bridge between the SLC-3 core's MAR/MDR path and on-chip SRAM, generalising the core's fixed single-cycle memory strobes into a valid/ready request channel and a one-cycle response pulse. The bridge has three jobs:
- insert a configurable number of SRAM read wait states;
- decode one memory-mapped I/O word (switches in, hex display out);
- report busy to the control FSM, so fetch/load/store states hold until the response arrives.

## Interface
Parameters:
- DATA_W, 16, data width of core, SRAM and I/O.
- ADDR_W, 16, address width.
- RD_LAT, 2, SRAM read latency in cycles; legal 1..15.
- IO_ADDR, all-ones (16'hFFFF for ADDR_W=16), address of the I/O word.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address (from MAR).
- req_wdata  in  DATA_W  write data (from MDR).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid is high.
- busy_o  out  1  request in flight (state other than IDLE).
- mem_ena  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data.
- sw_i  in  DATA_W  switches; asynchronous to clk.
- hex_o  out  DATA_W  hex display register.

## Operation
- States:
  - IDLE: req_ready=1.
  - MEM_RD: wait-state counter running.
  - MEM_WR: single SRAM write cycle.
  - RESP: rsp_valid=1.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. Request fields are latched at accept.
- Accept decode:
  - req_addr == IO_ADDR: go to RESP. A write loads hex_o at the accept edge. A read latches the synchronised sw_i into rsp_rdata.
  - SRAM read: go to MEM_RD and load the counter with RD_LAT-1.
  - SRAM write: go to MEM_WR.
- MEM_RD:
  - mem_ena=1, mem_we=0, mem_addr = latched address.
  - The counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into rsp_rdata and go to RESP.
- MEM_WR: mem_ena=1, mem_we=1, mem_addr/mem_wdata = latched values; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- Write responses drive rsp_rdata = 0.
- Outside MEM_RD/MEM_WR: mem_ena=0, mem_we=0. mem_addr and mem_wdata keep the last latched value.
- sw_i passes through a 2-flop synchroniser; reads return the synchronised value as of the accept edge.
- IO_ADDR never generates an SRAM access.
- Requests with req_valid low, or presented while not IDLE, are ignored. The core must hold them until accepted.
- Reset:
  - All outputs clear asynchronously except req_ready: rsp_valid, rsp_rdata, hex_o, mem_*, busy_o and the synchroniser flops go to 0.
  - req_ready=1 (state IDLE); the counter goes to 0.
  - Reset mid-operation abandons the access. mem_ena drops immediately, and no response is issued for the abandoned request.

## Timing
- Accept at edge k.
- SRAM read:
  - mem_ena high in cycles k+1 .. k+RD_LAT.
  - Data is sampled at the end of cycle k+RD_LAT.
  - rsp_valid is high in cycle k+RD_LAT+1.
  - Total RD_LAT+1 cycles from accept to response; RD_LAT=1 gives 2.
- SRAM write: mem_ena and mem_we high in cycle k+1; rsp_valid high in cycle k+2.
- I/O read or write: rsp_valid high in cycle k+1. hex_o shows the new value from cycle k+1.
- req_ready is low from cycle k+1 through the RESP cycle and returns high the cycle after RESP.
- Back-to-back throughput:
  - SRAM read: one per RD_LAT+2 cycles.
  - SRAM write: one per 3 cycles.
  - I/O access: one per 2 cycles.
- busy_o equals ~req_ready.
- Counter width is 4 bits. RD_LAT is treated as wrapping modulo 16: a value of 0 or greater than 15 is illegal and need not be detected.

## Test plan
- Reset, then SRAM read of 0x0010 with RD_LAT=2 and SRAM returning 0xBEEF:
  - mem_ena high for exactly 2 cycles, mem_addr=0x0010;
  - rsp_valid 1 cycle, 3 cycles after accept, rsp_rdata=0xBEEF.
- SRAM write 0x1234 to 0x0020: mem_we and mem_ena high in exactly one cycle with mem_addr=0x0020 and mem_wdata=0x1234; rsp_valid two cycles after accept.
- Write 0x00A5 to 0xFFFF, then read 0xFFFF with sw_i=0x3C00 held for at least 3 cycles:
  - hex_o=0x00A5;
  - no mem_ena pulse on either access;
  - read response rsp_rdata=0x3C00.
- req_valid held high with 4 queued reads, RD_LAT=1: exactly one accept per 3 cycles; no response lost or duplicated.
- Build with RD_LAT=15: response exactly 16 cycles after accept; req_ready low throughout.
- Assert reset in cycle k+1 of a read: mem_ena drops at once and no rsp_valid is issued. After release, hex_o=0 and a new request is accepted normally.
